multicycle_controller: RTL
==========================

# multicycle_controller

Multi-cycle sequencing FSM for the 32-bit core. It consumes the decoded control flags from the instruction decoder and steps each instruction through fetch, decode, execute, memory and write-back. Each step asserts the matching enables for PC, instruction register, register file, compare flags, data memory and kernel cache. It sits between the decoder and the datapath write enables, and also counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter
- TIMEOUT, 15, max wait cycles for imem/dmem ack (used only with MCCTRL_TIMEOUT_EN)

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- run  in  1  1 = start/keep issuing instructions; 0 = stop at next instruction boundary
- imem_ack  in  1  instruction memory data valid
- dmem_ack  in  1  data memory access complete
- selWB, selMEMRD, selMEMWR, selCPRS, selCACHEWR, selCACHESH, selBRANCH  in  1 each  decoder flags, stable while IR held
- imem_req  out  1  instruction fetch request
- ir_we  out  1  latch instruction register
- dmem_rd_req / dmem_wr_req  out  1 each  data memory read / write request
- reg_we  out  1  register file write
- cmp_we  out  1  compare-flag register write
- cache_wr_en / cache_sh_en  out  1 each  kernel cache write / shift
- pc_we  out  1  PC update
- pc_src  out  1  0 = PC+4, 1 = branch target
- busy  out  1  state != IDLE
- state  out  3  current state encoding
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W
- err  out  1  sticky ack timeout (0 when macro absent)

## Operation
- Registered state and counter. Outputs are combinational from state plus inputs.
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Codes 6–7 are illegal and recover to IDLE on the next edge.
- IDLE: all enables 0. Go to FETCH when run=1.
- FETCH: imem_req=1. On imem_ack: ir_we=1 in the same cycle, then go to DECODE. Otherwise hold.
- DECODE: no enables. Go to EXEC unconditionally.
- EXEC: cmp_we=selCPRS, cache_wr_en=selCACHEWR, cache_sh_en=selCACHESH, each for exactly one cycle.
  - If selMEMRD|selMEMWR: go to MEM.
  - Else if selWB: go to WB.
  - Else retire with pc_we=1, pc_src=0.
- MEM: dmem_rd_req=selMEMRD; dmem_wr_req=selMEMWR & ~selMEMRD (read wins if both set). Requests are held until dmem_ack. On ack: go to WB if selWB, else retire with pc_we=1, pc_src=0.
- WB:
  - If selBRANCH: pc_we=1, pc_src=1, reg_we=0.
  - Else: reg_we=1, pc_we=1, pc_src=0.
  - Then retire.
- Retire: instr_count+1 on the same edge. Next state is FETCH if run=1, else IDLE.
- run=0 mid-instruction: the instruction completes, then the FSM goes to IDLE. No request is dropped.
- rst mid-operation: immediately go to IDLE. All requests and enables drop in the same cycle; instr_count=0, err=0.

## Timing
- Reset values: every output 0; state=IDLE; instr_count=0.
- Latencies with zero-wait acks, counted from entering FETCH:
  - Compare or cache-only: 3 cycles.
  - ALU write-back or branch: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
- Each ack wait cycle adds one cycle.
- Back-to-back instructions: retire edge leads directly to FETCH; no bubble.
- ack is sampled only in FETCH (imem) and MEM (dmem). Stray acks in other states are ignored.

## Configuration
- MCCTRL_TIMEOUT_EN defined:
  - A wait counter clears on entry to FETCH/MEM and increments each cycle without ack.
  - When it reaches TIMEOUT: err=1 (sticky), requests drop, FSM goes to IDLE, no retire, no pc_we.
  - While err=1 the FSM stays in IDLE regardless of run, until rst.
- Undefined: waits indefinitely; err tied 0; no counter logic.

## Structure
- Package ctrl_pkg holds:
  - typedef enum logic [2:0] ctrl_state_t with the encodings above.
  - Constant PC_SRC_SEQ=0, PC_SRC_BR=1.
- One sub-module, ctrl_wait_timer (clear, tick, expired), instantiated only under MCCTRL_TIMEOUT_EN.

## Test plan
- Reset held, then released with run=1, imem_ack=1, ALU flags (selWB=1) → states 1,2,3,5; reg_we and pc_we high in WB; instr_count=1 after 4 cycles.
- Load (selWB=1, selMEMRD=1), dmem_ack delayed 3 cycles → dmem_rd_req high 4 cycles; retire at cycle 8; reg_we once.
- Branch (selBRANCH=1, selWB=1) → pc_src=1, pc_we=1, reg_we=0 in WB. Then store (selMEMWR=1): dmem_wr_req 1 cycle, no WB, pc_src=0.
- run dropped during MEM of a load → load completes, count increments, state=IDLE, busy=0; no further imem_req.
- rst asserted in MEM with dmem_rd_req high → all outputs 0 asynchronously, state=IDLE, instr_count=0.
- With MCCTRL_TIMEOUT_EN, TIMEOUT=15, imem_ack held 0 → err=1 after 15 FETCH cycles, state=IDLE, stays IDLE with run=1 until rst.

Source files
------------

// File: rtl/multicycle_controller_pkg.sv
// Shared types for the multi-cycle sequencing controller: state encoding and PC source select.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } ctrl_state_t;

  localparam logic PC_SRC_SEQ = 1'b0;
  localparam logic PC_SRC_BR  = 1'b1;

  // States that wait on an external memory acknowledge.
  function automatic logic is_wait_state(ctrl_state_t s);
    return (s == ST_FETCH) || (s == ST_MEM);
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Decoder flags, memory handshakes and datapath enables of the multi-cycle controller.
// master = controller side, slave = decoder/datapath/memory side.
interface multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic             run;
  logic             imem_ack;
  logic             dmem_ack;
  logic             selWB;
  logic             selMEMRD;
  logic             selMEMWR;
  logic             selCPRS;
  logic             selCACHEWR;
  logic             selCACHESH;
  logic             selBRANCH;

  logic             imem_req;
  logic             ir_we;
  logic             dmem_rd_req;
  logic             dmem_wr_req;
  logic             reg_we;
  logic             cmp_we;
  logic             cache_wr_en;
  logic             cache_sh_en;
  logic             pc_we;
  logic             pc_src;
  logic             busy;
  logic [2:0]       state;
  logic [CNT_W-1:0] instr_count;
  logic             err;

  modport master (
    input  run, imem_ack, dmem_ack,
    input  selWB, selMEMRD, selMEMWR, selCPRS, selCACHEWR, selCACHESH, selBRANCH,
    output imem_req, ir_we, dmem_rd_req, dmem_wr_req, reg_we, cmp_we,
    output cache_wr_en, cache_sh_en, pc_we, pc_src, busy, state, instr_count, err
  );

  modport slave (
    output run, imem_ack, dmem_ack,
    output selWB, selMEMRD, selMEMWR, selCPRS, selCACHEWR, selCACHESH, selBRANCH,
    input  imem_req, ir_we, dmem_rd_req, dmem_wr_req, reg_we, cmp_we,
    input  cache_wr_en, cache_sh_en, pc_we, pc_src, busy, state, instr_count, err
  );

endinterface

// File: rtl/multicycle_controller_wait_timer.sv
// Ack wait counter: counts consecutive wait cycles and flags the cycle that reaches LIMIT.
module ctrl_wait_timer #(
  parameter int LIMIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic tick,
  output logic expired
);

  localparam int W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (tick) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  // The LIMIT-th waiting cycle is the last one spent waiting.
  assign expired = tick && (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with retired-instruction counter.
// Optional ack timeout with sticky err is built when MCCTRL_TIMEOUT_EN is defined.
//
// state  | meaning
// IDLE   | no instruction in flight, waiting for run
// FETCH  | instruction fetch request, latch IR on imem_ack
// DECODE | decoder settles on the new IR
// EXEC   | compare/cache enables, pick MEM/WB/retire
// MEM    | data memory request held until dmem_ack
// WB     | register write-back or branch PC update, retire
module multicycle_controller
  import ctrl_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15
) (
  input logic clk,
  input logic rst,
  multicycle_controller_if.master bus
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("multicycle_controller: TIMEOUT must be at least 1");
  end

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic             retire;
  logic             tmo;
  logic             halt;

  logic imem_req, ir_we, dmem_rd_req, dmem_wr_req, reg_we, cmp_we;
  logic cache_wr_en, cache_sh_en, pc_we, pc_src;

`ifdef MCCTRL_TIMEOUT_EN
  logic tmr_tick, tmr_expired, err_q;

  // Any ack (or leaving the wait states) restarts the count for the next wait.
  assign tmr_tick = (state_q == ST_FETCH && !bus.imem_ack) ||
                    (state_q == ST_MEM   && !bus.dmem_ack);

  ctrl_wait_timer #(
    .LIMIT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (!tmr_tick),
    .tick    (tmr_tick && is_wait_state(state_q)),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (tmr_expired) begin
      err_q <= 1'b1;
    end
  end

  assign tmo     = tmr_expired;
  assign halt    = err_q;
  assign bus.err = err_q;
`else
  assign tmo     = 1'b0;
  assign halt    = 1'b0;
  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (retire) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_rd_req = 1'b0;
    dmem_wr_req = 1'b0;
    reg_we      = 1'b0;
    cmp_we      = 1'b0;
    cache_wr_en = 1'b0;
    cache_sh_en = 1'b0;
    pc_we       = 1'b0;
    pc_src      = PC_SRC_SEQ;

    case (state_q)
      ST_IDLE: begin
        if (bus.run && !halt) state_d = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_we   = 1'b1;
          state_d = ST_DECODE;
        end else if (tmo) begin
          state_d = ST_IDLE;
        end
      end

      ST_DECODE: begin
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        cmp_we      = bus.selCPRS;
        cache_wr_en = bus.selCACHEWR;
        cache_sh_en = bus.selCACHESH;
        if (bus.selMEMRD || bus.selMEMWR) begin
          state_d = ST_MEM;
        end else if (bus.selWB) begin
          state_d = ST_WB;
        end else begin
          pc_we  = 1'b1;
          retire = 1'b1;
        end
      end

      ST_MEM: begin
        // A read and a write flagged together resolve to the read.
        dmem_rd_req = bus.selMEMRD;
        dmem_wr_req = bus.selMEMWR && !bus.selMEMRD;
        if (bus.dmem_ack) begin
          if (bus.selWB) begin
            state_d = ST_WB;
          end else begin
            pc_we  = 1'b1;
            retire = 1'b1;
          end
        end else if (tmo) begin
          state_d = ST_IDLE;
        end
      end

      ST_WB: begin
        pc_we  = 1'b1;
        retire = 1'b1;
        if (bus.selBRANCH) begin
          pc_src = PC_SRC_BR;
        end else begin
          reg_we = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (retire) state_d = bus.run ? ST_FETCH : ST_IDLE;
  end

  assign bus.imem_req    = imem_req;
  assign bus.ir_we       = ir_we;
  assign bus.dmem_rd_req = dmem_rd_req;
  assign bus.dmem_wr_req = dmem_wr_req;
  assign bus.reg_we      = reg_we;
  assign bus.cmp_we      = cmp_we;
  assign bus.cache_wr_en = cache_wr_en;
  assign bus.cache_sh_en = cache_sh_en;
  assign bus.pc_we       = pc_we;
  assign bus.pc_src      = pc_src;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.state       = state_q;
  assign bus.instr_count = count_q;

endmodule
